// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_scheduler : round-robin packet scheduler in front of one UART transmitter
// Revision          : 1.0
// ----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_TICKS  = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          baudTick,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [PTR_W-1:0]      ptr, ptr_nxt;
  logic                  last_q, last_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0]    req_ack_nxt, grant_nxt;
  logic                  tx_start_nxt, busy_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt, sel_data;
  logic [PTR_W-1:0]      pick, cand;
  logic                  pick_valid;
  logic                  load_fire;

  // Walk from the farthest candidate towards ptr+1 so the nearest one wins.
  always_comb begin : p_pick
    int idx;
    pick       = ptr;
    pick_valid = 1'b0;
    cand       = '0;
    idx        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(ptr) + k) % NUM_REQ;
      cand = PTR_W'(idx);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin : p_sel
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ptr == PTR_W'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign load_fire = tx_ready && req[ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= S_IDLE;
      ptr      <= PTR_W'(NUM_REQ - 1);
      last_q   <= 1'b0;
      gap_cnt  <= '0;
      req_ack  <= '0;
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      last_q   <= last_nxt;
      gap_cnt  <= gap_cnt_nxt;
      req_ack  <= req_ack_nxt;
      grant    <= grant_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin : p_next
    state_nxt = state;
    case (state)
      S_IDLE:      if (pick_valid) state_nxt = S_LOAD;
      S_LOAD:      if (load_fire) state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_ready) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_ready) begin
          if (!last_q)             state_nxt = S_LOAD;
          else if (GAP_TICKS == 0) state_nxt = S_IDLE;
          else                     state_nxt = S_GAP;
        end
      end
      S_GAP:       if (baudTick && (gap_cnt == GAP_LAST)) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ptr doubles as the granted index.
  always_comb begin : p_out
    ptr_nxt      = ptr;
    last_nxt     = last_q;
    gap_cnt_nxt  = gap_cnt;
    grant_nxt    = grant;
    req_ack_nxt  = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    busy_nxt     = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          ptr_nxt   = pick;
          grant_nxt = NUM_REQ'(1) << pick;
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = sel_data;
          req_ack_nxt  = grant;
          last_nxt     = req_last[ptr];
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready && last_q) begin
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
        end
      end
      S_GAP: begin
        if (baudTick) gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// tb_uart_tx_scheduler : scoreboard bench with requester, transmitter and serial-decoder models.
module tb_uart_tx_scheduler;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int GAP = 16;

  logic            clk = 1'b0;
  logic            rstN;
  logic            baudTick;
  logic [NR-1:0]   req, req_last, req_ack, grant;
  logic [NR*DW-1:0] req_data;
  logic            tx_ready, tx_start, busy;
  logic [DW-1:0]   tx_data;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rstN(rstN), .baudTick(baudTick),
    .req(req), .req_data(req_data), .req_last(req_last), .req_ack(req_ack),
    .grant(grant), .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard state: bytes offered per requester, expected bytes per owner,
  // expected grant order, and bytes expected back from the serial line.
  logic [8:0]    pkt_q [NR][$];
  logic [8:0]    exp_q [NR][$];
  logic [NR-1:0] exp_grant [$];
  logic [7:0]    ser_q [$];

  int start_cnt = 0;
  int ack_cnt [NR];

  task automatic load_byte(input int i, input logic [7:0] b, input logic last);
    pkt_q[i].push_back({last, b});
    exp_q[i].push_back({last, b});
  endtask

  // Environment: baud ticks, transmitter, serial decoder, requesters.
  logic       model_busy = 1'b0;
  logic [9:0] shreg;
  int         bitcnt;
  logic       line = 1'b1;
  logic       rx_act = 1'b0;
  int         rx_n;
  logic [7:0] rx_sh;
  int         cyc = 0;
  logic       force_low = 1'b0;
  logic       glitch = 1'b0;
  int         hold_cnt [NR];
  int         stall_req [NR];
  int         stall_bad = 0;

  initial begin
    baudTick = 1'b0; tx_ready = 1'b1; req = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin hold_cnt[i] = 0; stall_req[i] = 0; ack_cnt[i] = 0; end
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (baudTick && model_busy) begin
        if (bitcnt == 10) model_busy = 1'b0;
        else begin line = shreg[0]; shreg = shreg >> 1; bitcnt++; end
      end
      if (baudTick) begin
        if (!rx_act) begin
          if (!line) begin rx_act = 1'b1; rx_n = 0; end
        end else if (rx_n < 8) begin
          rx_sh[rx_n] = line; rx_n++;
        end else begin
          rx_act = 1'b0;
          check("serial_stop_bit", line, 1);
          if (ser_q.size() == 0) check("serial_extra_frame", rx_sh, 0);
          else check("serial_byte", rx_sh, ser_q.pop_front());
        end
      end
      if (tx_start) begin
        check("start_while_tx_busy", model_busy, 0);
        if (!model_busy) begin shreg = {1'b1, tx_data, 1'b0}; bitcnt = 0; model_busy = 1'b1; end
      end
      tx_ready = !model_busy && !force_low && !(glitch && (cyc % 4 != 0));
      baudTick = (cyc % 2 == 1);
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i]) begin
          if (pkt_q[i].size() > 0) void'(pkt_q[i].pop_front());
          if (stall_req[i] > 0) begin hold_cnt[i] = stall_req[i]; stall_req[i] = 0; end
        end else if (hold_cnt[i] > 0) begin
          if (tx_start || grant != NR'(1 << i) || !busy) stall_bad++;
          hold_cnt[i]--;
        end
        if (pkt_q[i].size() > 0 && hold_cnt[i] == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = pkt_q[i][0][7:0];
          req_last[i] = pkt_q[i][0][8];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [NR-1:0] prev_grant = '0;
  logic          prev_busy = 1'b0;
  logic          prev_start = 1'b0;
  int            gap_ticks = 0;

  always @(negedge clk) begin
    if (!rstN) begin
      prev_grant = '0; prev_busy = 1'b0; prev_start = 1'b0; gap_ticks = 0;
    end else begin
      int owner;
      logic [8:0] e;
      if (prev_grant != '0 && grant == '0) gap_ticks = 0;
      if (busy && grant == '0 && baudTick) gap_ticks++;
      if (prev_busy && !busy) check("gap_ticks", gap_ticks, GAP);
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant.size() == 0) check("grant_unexpected", grant, 0);
        else check("grant_order", grant, exp_grant.pop_front());
      end
      if (tx_start || req_ack != '0) check("ack_matches_grant", req_ack, tx_start ? grant : '0);
      if (tx_start) begin
        check("start_pulse_width", prev_start, 0);
        owner = -1;
        for (int i = 0; i < NR; i++) if (grant[i]) owner = i;
        if (owner < 0 || exp_q[owner].size() == 0) check("start_unexpected", tx_start, 0);
        else begin
          e = exp_q[owner].pop_front();
          check("tx_data", tx_data, e[7:0]);
          ser_q.push_back(e[7:0]);
        end
        start_cnt++;
      end
      for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
      prev_grant = grant; prev_busy = busy; prev_start = tx_start;
    end
  end

  function automatic bit pending();
    bit p = (exp_grant.size() != 0) || (ser_q.size() != 0) || rx_act;
    for (int i = 0; i < NR; i++) if (pkt_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while ((busy || model_busy || pending()) && n < max) begin @(posedge clk); n++; end
    check("drain_in_time", n < max, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_grant(input int max);
    int n = 0;
    while (grant == '0 && n < max) begin @(posedge clk); n++; end
    check("grant_in_time", n < max, 1);
  endtask

  task automatic wait_starts(input int target, input int max);
    int n = 0;
    while (start_cnt < target && n < max) begin @(posedge clk); n++; end
    check("starts_in_time", n < max, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ack"}, req_ack, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int s, a;
    rstN = 1'b1;
    // All four requesting through reset; requester 0 has a second packet.
    load_byte(0, 8'hA5, 1'b1); load_byte(1, 8'h12, 1'b1);
    load_byte(2, 8'h34, 1'b1); load_byte(3, 8'h56, 1'b1);
    load_byte(0, 8'hC3, 1'b1);
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk); #2;
    check_outputs_zero("reset");
    @(negedge clk) rstN = 1'b1;
    drain(3000);
    for (int i = 0; i < NR; i++) check("rr_acks", ack_cnt[i], (i == 0) ? 2 : 1);

    // Multi-byte packet from requester 2, requester 1 joins mid-packet.
    s = start_cnt; a = ack_cnt[2];
    exp_grant.push_back(4'b0100);
    load_byte(2, 8'h11, 1'b0); load_byte(2, 8'h22, 1'b0); load_byte(2, 8'h33, 1'b1);
    wait_grant(100);
    exp_grant.push_back(4'b0010);
    load_byte(1, 8'h44, 1'b1);
    drain(3000);
    check("mb_acks_req2", ack_cnt[2] - a, 3);
    check("mb_starts", start_cnt - s, 4);

    // Transmitter not ready for 200 cycles after grant.
    force_low = 1'b1; s = start_cnt;
    exp_grant.push_back(4'b0010);
    load_byte(1, 8'h96, 1'b1);
    wait_grant(50);
    repeat (200) @(posedge clk);
    check("hs_no_start_while_low", start_cnt - s, 0);
    force_low = 1'b0;
    drain(1000);
    check("hs_single_start", start_cnt - s, 1);

    // Requester 0 withdraws for 50 cycles after its first byte.
    s = start_cnt; a = ack_cnt[0]; stall_bad = 0; stall_req[0] = 50;
    exp_grant.push_back(4'b0001);
    load_byte(0, 8'h5A, 1'b0); load_byte(0, 8'h6B, 1'b0); load_byte(0, 8'h7C, 1'b1);
    drain(3000);
    check("stall_held_no_start", stall_bad, 0);
    check("stall_acks", ack_cnt[0] - a, 3);
    check("stall_starts", start_cnt - s, 3);

    // Bouncing tx_ready while a two-byte packet is pending.
    glitch = 1'b1; s = start_cnt;
    exp_grant.push_back(4'b0100);
    load_byte(2, 8'h81, 1'b0); load_byte(2, 8'h7E, 1'b1);
    drain(3000);
    glitch = 1'b0;
    check("glitch_starts", start_cnt - s, 2);

    // Reset while byte 2 of 3 is on the line.
    s = start_cnt;
    exp_grant.push_back(4'b0001);
    load_byte(0, 8'hD1, 1'b0); load_byte(0, 8'hD2, 1'b0); load_byte(0, 8'hD3, 1'b1);
    wait_starts(s + 2, 500);
    repeat (3) @(posedge clk);
    check("mr_in_wait_done", tx_ready, 0);
    #3 rstN = 1'b0;
    #1 check_outputs_zero("midreset");
    pkt_q[0].delete(); exp_q[0].delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    load_byte(1, 8'hE1, 1'b1); load_byte(0, 8'hE0, 1'b1);
    drain(3000);

    for (int i = 0; i < NR; i++) check("exp_bytes_left", exp_q[i].size(), 0);
    check("serial_bytes_left", ser_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` requesters on the serial bus. Each requester offers a packet as a byte stream with a last-byte flag. The scheduler grants one requester for a whole packet and sequences each byte into the transmitter through its start/ready handshake. It then enforces an idle gap, counted in baud ticks, before the next arbitration.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: byte width.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_TICKS`, default 16: `baudTick` pulses of idle line after each packet. A value of 0 means no gap.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rstN`, in, 1: asynchronous, active-low reset.
- `baudTick`, in, 1: one-cycle pulse from `uart_baudRateGen`.
- `req`, in, `NUM_REQ`: requester i has a valid byte.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`, in, `NUM_REQ`: byte of requester i is the last of its packet.
- `req_ack`, out, `NUM_REQ`: one-cycle pulse that consumes the current byte of requester i.
- `grant`, out, `NUM_REQ`: one-hot owner of the transmitter, or all zero.
- `tx_ready`, in, 1: transmitter idle.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data`, out, `DATA_WIDTH`: byte to the transmitter, valid while `tx_start`=1 and held afterwards.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- All outputs are registered.
- Reset values: `req_ack`=0, `grant`=0, `tx_start`=0, `tx_data`=0, `busy`=0, state IDLE, `ptr`=`NUM_REQ-1`. With this `ptr`, requester 0 has the highest priority after reset.
- `ptr` has width `$clog2(NUM_REQ)` and holds the index of the last granted requester.

States:
- IDLE: if any `req` bit is 1, grant the first requester with `req`=1, searching `ptr+1`, `ptr+2`, ... modulo `NUM_REQ`. Set `grant` to that one-hot value, update `ptr`, set `busy`=1, go to LOAD. If `req` is all zero, stay in IDLE.
- LOAD: wait until `tx_ready`=1 and `req[g]`=1, where g is the granted requester. Then, for exactly one cycle, drive `tx_start`=1, `tx_data`=`req_data[g]` and `req_ack[g]`=1. Latch `req_last[g]` and go to WAIT_BUSY.
  - If `req[g]` drops mid-packet, the grant is held and the scheduler stalls in LOAD. There is no timeout.
- WAIT_BUSY: wait for `tx_ready`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_ready`=1.
  - Latched last=1: clear `grant` and go to GAP, or to IDLE if `GAP_TICKS`=0.
  - Latched last=0: go to LOAD.
- GAP: count `baudTick` pulses. On the `GAP_TICKS`-th pulse, go to IDLE. `req` is ignored during GAP.

Requester rules:
- Hold `req`, `req_data` and `req_last` stable until `req_ack` is seen.
- The next byte may be presented from the cycle after `req_ack`.
- `req_ack` never pulses for a requester that is not granted.

Other rules:
- New `req` assertions in any state other than IDLE do not affect the current grant.
- `tx_data` holds its last value until the next start pulse.

## Timing
- IDLE to `grant` valid: 1 cycle after `req` is sampled.
- `grant` to first `tx_start`: 1 cycle minimum (LOAD entry, then the pulse), longer while `tx_ready`=0.
- `tx_start` and `req_ack` are asserted in the same cycle and both are exactly 1 cycle wide.
- The transmitter must drop `tx_ready` within a few cycles of `tx_start`. The scheduler never issues a second start before it has seen `tx_ready` go low and then high again.
- A `baudTick` in the cycle of GAP entry is not counted. Counting starts the cycle after entry.
- Simultaneous requests in IDLE are resolved in one cycle by round-robin order only.
- A single-requester system re-grants the same requester after the gap.
- Reset mid-operation: all outputs clear asynchronously and state returns to IDLE. A frame already started in the transmitter completes on its own, and the aborted packet is not resumed.

## Test plan
- Reset: with `req`=4'b1111 held during reset, all outputs are 0. After release, `grant`=4'b0001 is the first grant. A 1-byte packet 0xA5 produces one `tx_start` with `tx_data`=0xA5 and one `req_ack[0]` pulse.
- Round-robin: with all four requesters sending 1-byte packets continuously, the grant order is 0,1,2,3,0. Each packet is followed by at least `GAP_TICKS`=16 `baudTick` pulses with `tx_start`=0. Pair the scheduler with `uart_baudRateGen` at 19200 baud and a transmitter model, and confirm the serial stream decodes back through `uart_receiver`.
- Multi-byte packet: requester 2 sends 0x11, 0x22, 0x33 (last on 0x33) while requester 1 is requesting. Requirements:
  - `grant`=4'b0100 is held for all 3 bytes.
  - Exactly 3 `req_ack[2]` pulses occur.
  - Requester 1 is granted only after the gap.
- Stall: requester 0 drops `req` for 50 cycles between bytes. The scheduler stays in LOAD with the grant held and no `tx_start`, then resumes with the next byte.
- Handshake: hold `tx_ready` low for 200 cycles after `grant`. No `tx_start` occurs until `tx_ready` rises, then exactly one pulse follows. Check that `tx_ready` glitches never cause a double start.
- Reset mid-packet: assert `rstN`=0 in WAIT_DONE of byte 2 of 3. Outputs go to 0 immediately. After release, arbitration restarts from requester 0.
